ssd_scan_decoder: RTL

//  Receive-side counterpart of the 4-digit multiplexed seven-segment scan driver.

---
 rtl/ssd_scan_decoder.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/ssd_scan_decoder.sv
// Receive-side decoder for a 4-digit multiplexed seven-segment scan. It samples each settled
// anode phase, maps the glyph back to a hex nibble and flags stalls and illegal patterns.
module ssd_scan_decoder #(
  parameter int unsigned SETTLE_CYC  = 16,
  parameter int unsigned TIMEOUT_CYC = 1048576
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_an,
  input  logic [7:0] i_cath,
  output logic [3:0] o_digit3,
  output logic [3:0] o_digit2,
  output logic [3:0] o_digit1,
  output logic [3:0] o_digit0,
  output logic [3:0] o_dp_out,
  output logic [3:0] o_digit_valid,
  output logic       o_frame_done,
  output logic       o_glyph_err,
  output logic       o_anode_err,
  output logic       o_stale
);

  localparam int unsigned SW = $clog2(SETTLE_CYC + 1);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [SW-1:0] SETTLE_MAX  = SW'(SETTLE_CYC);
  localparam logic [SW-1:0] SETTLE_HIT  = SW'(SETTLE_CYC - 2);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYC);
  localparam logic [TW-1:0] TIMEOUT_HIT = TW'(TIMEOUT_CYC - 2);

  logic [3:0]    r_an_s1, r_an_s2, r_an_prev;
  logic [7:0]    r_cath_s1, r_cath_s2;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_idle;
  logic [3:0]    r_mask;
  logic [3:0]    r_digit [4];
  logic [3:0]    r_dp, r_valid;
  logic          r_frame, r_gerr, r_aerr, r_stale;

  logic       w_an_chg, w_sample, w_idle_hit;
  logic       w_one_low, w_multi_low, w_hit;
  logic [1:0] w_sel;
  logic [3:0] w_nib, w_mask_base;

  // Counters advance on the edge that moves them to SETTLE-1 / TIMEOUT-1, so the event
  // is gated on the pre-edge value and cancelled by a coincident anode change.
  assign w_an_chg    = (r_an_s2 != r_an_prev);
  assign w_sample    = !w_an_chg && (r_settle == SETTLE_HIT);
  assign w_idle_hit  = !w_an_chg && (r_idle == TIMEOUT_HIT);
  assign w_multi_low = !$onehot0(~r_an_s2);
  assign w_mask_base = (r_mask == 4'hF) ? 4'h0 : r_mask;

  always_comb begin
    w_sel     = 2'd0;
    w_one_low = 1'b1;
    case (r_an_s2)
      4'b1110: w_sel = 2'd0;
      4'b1101: w_sel = 2'd1;
      4'b1011: w_sel = 2'd2;
      4'b0111: w_sel = 2'd3;
      default: w_one_low = 1'b0;
    endcase
  end

  always_comb begin
    w_hit = 1'b1;
    w_nib = 4'h0;
    case (r_cath_s2[7:1])
      7'h01: w_nib = 4'h0;
      7'h4F: w_nib = 4'h1;
      7'h12: w_nib = 4'h2;
      7'h06: w_nib = 4'h3;
      7'h4C: w_nib = 4'h4;
      7'h24: w_nib = 4'h5;
      7'h20: w_nib = 4'h6;
      7'h0F: w_nib = 4'h7;
      7'h00: w_nib = 4'h8;
      7'h04: w_nib = 4'h9;
      7'h08: w_nib = 4'hA;
      7'h60: w_nib = 4'hB;
      7'h31: w_nib = 4'hC;
      7'h42: w_nib = 4'hD;
      7'h30: w_nib = 4'hE;
      7'h38: w_nib = 4'hF;
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_an_s1   <= 4'hF;
      r_an_s2   <= 4'hF;
      r_an_prev <= 4'hF;
      r_cath_s1 <= 8'hFF;
      r_cath_s2 <= 8'hFF;
      r_settle  <= '0;
      r_idle    <= '0;
      r_mask    <= 4'h0;
      for (int i = 0; i < 4; i++) r_digit[i] <= 4'h0;
      r_dp      <= 4'h0;
      r_valid   <= 4'h0;
      r_frame   <= 1'b0;
      r_gerr    <= 1'b0;
      r_aerr    <= 1'b0;
      r_stale   <= 1'b0;
    end else begin
      r_an_s1   <= i_an;
      r_an_s2   <= r_an_s1;
      r_an_prev <= r_an_s2;
      r_cath_s1 <= i_cath;
      r_cath_s2 <= r_cath_s1;
      r_frame   <= 1'b0;
      r_gerr    <= 1'b0;
      r_aerr    <= 1'b0;

      if (w_an_chg) begin
        r_settle <= '0;
        r_idle   <= '0;
        r_stale  <= 1'b0;
      end else begin
        if (r_settle != SETTLE_MAX) r_settle <= r_settle + SW'(1);
        if (r_idle != TIMEOUT_MAX) r_idle <= r_idle + TW'(1);
      end

      if (r_mask == 4'hF) begin
        r_frame <= 1'b1;
        r_mask  <= 4'h0;
      end

      if (w_idle_hit) begin
        r_stale <= 1'b1;
        r_valid <= 4'h0;
        r_mask  <= 4'h0;
      end else if (w_sample) begin
        if (w_one_low) begin
          if (w_hit) begin
            r_digit[w_sel] <= w_nib;
            r_dp[w_sel]    <= ~r_cath_s2[0];
            r_valid[w_sel] <= 1'b1;
            r_mask         <= w_mask_base | (4'b0001 << w_sel);
          end else begin
            r_gerr         <= 1'b1;
            r_valid[w_sel] <= 1'b0;
          end
        end else if (w_multi_low) begin
          r_aerr <= 1'b1;
        end
      end
    end
  end

  assign o_digit3      = r_digit[3];
  assign o_digit2      = r_digit[2];
  assign o_digit1      = r_digit[1];
  assign o_digit0      = r_digit[0];
  assign o_dp_out      = r_dp;
  assign o_digit_valid = r_valid;
  assign o_frame_done  = r_frame;
  assign o_glyph_err   = r_gerr;
  assign o_anode_err   = r_aerr;
  assign o_stale       = r_stale;

endmodule
